// File: rtl/yarp_muldiv.sv
// yarp_muldiv: iterative RISC-V M-extension multiply/divide unit.
//
// One radix-2 step per cycle. Multiply is shift-add into a 2*XLEN product;
// divide is restoring division on operand magnitudes. Signs are restored when
// the last step completes. Divide-by-zero and signed overflow results are
// computed at accept time. With EARLY_OUT=1 they finish straight away;
// otherwise they run the full iteration count and return the same value.
//
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid_i   request valid
//   in_ready_o   unit idle and able to accept a request
//   op_i         RISC-V funct3 (md_op_e)
//   opa_i/opb_i  rs1 / rs2 operands
//   flush_i      abandon any in-flight operation (beats accept and handshake)
//   out_valid_o  result valid (held until out_ready_i)
//   out_ready_i  consumer accepts result
//   result_o     result
//   busy_o       unit not idle

package yarp_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;
endpackage

module yarp_muldiv
    import yarp_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned     CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    md_op_e              op_q, op_d;
    logic                a_neg_q, a_neg_d;
    logic                b_neg_q, b_neg_d;
    logic [XLEN-1:0]     opb_mag_q, opb_mag_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     spec_res_q, spec_res_d;
    logic [XLEN-1:0]     result_q, result_d;

    // ------------------------------------------------------------------
    // Request decode: operand signs, magnitudes and special divide cases
    // ------------------------------------------------------------------
    md_op_e          op_in;
    logic            in_a_signed, in_b_signed;
    logic            in_a_neg, in_b_neg;
    logic            in_dz, in_ovf, in_special;
    logic [XLEN-1:0] in_a_mag, in_b_mag, in_spec_res;

    always_comb begin
        op_in       = md_op_e'(op_i);
        // MULHSU treats only rs1 as signed.
        in_a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
        in_b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        in_a_neg    = in_a_signed & opa_i[XLEN-1];
        in_b_neg    = in_b_signed & opb_i[XLEN-1];
        in_a_mag    = in_a_neg ? (~opa_i + 1'b1) : opa_i;
        in_b_mag    = in_b_neg ? (~opb_i + 1'b1) : opb_i;
        in_dz       = (opb_i == '0);
        in_ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (opa_i == MIN_NEG) && (opb_i == '1);
        in_special  = op_i[2] && (in_dz || in_ovf);
        // op_i[1] separates REM/REMU from DIV/DIVU.
        if (op_i[1]) begin
            in_spec_res = in_dz ? opa_i : '0;
        end else begin
            in_spec_res = in_dz ? '1 : opa_i;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step and final sign correction
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_nx, prod_fin;
    logic [XLEN-1:0]   quo_nx, rem_nx, quo_fin, rem_fin, fin_res;
    logic              neg_res;

    always_comb begin
        // Shift-add: low half holds the remaining multiplier bits, high half
        // accumulates; the carry is kept by shifting the XLEN+1 sum right.
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    (prod_q[0] ? {1'b0, opb_mag_q} : {(XLEN+1){1'b0}});
        prod_nx   = {mul_sum, prod_q[XLEN-1:1]};

        // Restoring divide: quo_q shifts the dividend out at the top while
        // quotient bits enter at the bottom.
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_mag_q};
        rem_nx    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        quo_nx    = {quo_q[XLEN-2:0], ~div_diff[XLEN]};

        neg_res   = a_neg_q ^ b_neg_q;
        prod_fin  = neg_res ? (~prod_nx + 1'b1) : prod_nx;
        quo_fin   = neg_res ? (~quo_nx + 1'b1) : quo_nx;
        // Remainder takes the sign of the dividend.
        rem_fin   = a_neg_q ? (~rem_nx + 1'b1) : rem_nx;

        fin_res = rem_fin;
        case (op_q)
            OP_MUL:                        fin_res = prod_fin[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_fin[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fin_res = quo_fin;
            default:                       fin_res = rem_fin;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        opb_mag_d  = opb_mag_q;
        prod_d     = prod_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i && !flush_i) begin
                    op_d       = op_in;
                    a_neg_d    = in_a_neg;
                    b_neg_d    = in_b_neg;
                    opb_mag_d  = in_b_mag;
                    prod_d     = {{XLEN{1'b0}}, in_a_mag};
                    quo_d      = in_a_mag;
                    rem_d      = '0;
                    spec_d     = in_special;
                    spec_res_d = in_spec_res;
                    cnt_d      = CNT_W'(XLEN - 1);
                    if (EARLY_OUT && in_special) begin
                        state_d  = DONE;
                        result_d = in_spec_res;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                prod_d = prod_nx;
                quo_d  = quo_nx;
                rem_d  = rem_nx;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    // Special cases ran the loop only for timing; their
                    // answer was fixed at accept.
                    result_d = spec_q ? spec_res_q : fin_res;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MUL;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            opb_mag_q  <= '0;
            prod_q     <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            opb_mag_q  <= opb_mag_d;
            prod_q     <= prod_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;

endmodule

// File: doc/yarp_muldiv.md
YARP_MULDIV -- requirements
Module: yarp_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand/result width; legal values are 32 and 64.
REQ-002 SHALL have parameter EARLY_OUT, default 1; when 1, special-case divides complete in 1 cycle.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1, request valid.
REQ-006 SHALL have port in_ready_o, output, 1, unit can accept a request.
REQ-007 SHALL have port op_i, input, 3, operation; encoding is RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; declared as enum md_op_e in yarp_pkg.
REQ-008 SHALL have port opa_i, input, XLEN, rs1 operand.
REQ-009 SHALL have port opb_i, input, XLEN, rs2 operand.
REQ-010 SHALL have port flush_i, input, 1, abandon any in-flight operation.
REQ-011 SHALL have port out_valid_o, output, 1, result valid.
REQ-012 SHALL have port out_ready_i, input, 1, consumer accepts result.
REQ-013 SHALL have port result_o, output, XLEN, result.
REQ-014 SHALL have port busy_o, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 SHALL drive in_ready_o = 1 only in IDLE; a request is accepted on an edge where in_valid_i & in_ready_o & !flush_i, latching op, operands and operand signs.
REQ-017 SHALL, on accept, go to BUSY with iteration counter = XLEN-1, on magnitudes (signed ops use two's-complement absolute value; MULHSU treats only opa as signed).
REQ-018 SHALL perform one radix-2 iteration per BUSY cycle: shift-add multiply into a 2*XLEN product, or restoring divide producing one quotient bit.
REQ-019 SHALL go BUSY->DONE on the edge where counter = 0, applying sign correction at that point; nominal latency: out_valid_o rises XLEN+1 edges after the accept edge.
REQ-020 SHALL select product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for MULH/MULHSU/MULHU.
REQ-021 SHALL negate the quotient when the operand signs differ (DIV) and give the remainder the sign of the dividend (REM).
REQ-022 SHALL return quotient all-ones and remainder = opa_i for divide by zero (signed and unsigned).
REQ-023 SHALL return quotient = opa_i and remainder 0 for signed overflow (opa = most negative, opb = -1).
REQ-024 SHALL, when EARLY_OUT = 1, send the REQ-022/023 cases IDLE->DONE directly (out_valid_o 1 edge after accept); when 0, run the full XLEN iterations with an identical result.
REQ-025 SHALL hold out_valid_o and a stable result_o in DONE until out_ready_i; on the handshake edge go to IDLE.
REQ-026 SHALL make in_ready_o low in DONE: there is no same-cycle result-out/request-in overlap.
REQ-027 SHALL, when flush_i = 1 in any state, go to IDLE on the next edge with out_valid_o = 0, discarding the result; flush has priority over accept and over the output handshake.

Reset
REQ-028 SHALL, while reset_n = 0, force state IDLE, counter 0, product/quotient/remainder registers 0, result_o 0, out_valid_o 0, busy_o 0, in_ready_o 1.
REQ-029 SHALL abort any in-flight operation on reset assertion; no result is produced after release.

Verification
REQ-030 SHALL cover MUL opa=7 opb=0xFFFFFFFD (XLEN=32) -> result 0xFFFFFFEB with out_valid_o 33 edges after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-032 SHALL cover DIVU 0x1234 / 0 -> 0xFFFFFFFF and REMU 0x1234 / 0 -> 0x1234, out_valid_o 1 edge after accept (EARLY_OUT=1) and 33 edges after accept (EARLY_OUT=0).
REQ-033 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0.
REQ-034 SHALL cover out_ready_i held low 10 cycles in DONE -> result_o stable, in_ready_o 0, busy_o 1; then out_ready_i=1 -> IDLE the next edge.
REQ-035 SHALL cover flush_i at BUSY cycle 5 and reset_n low at BUSY cycle 10 -> IDLE and out_valid_o never asserted; then a new MUL 3x4 -> 12 completes normally.
